// File: rtl/core_pkg.sv
// Shared instruction-word layout and FSM phase encodings for the decoder slice.
package core_pkg;
   localparam int INST_W     = 35;
   localparam int ADDR_W     = 11;
   localparam int MODE_B     = 34;
   localparam int ACC_B      = 33;
   localparam int CEN_P_B    = 32;
   localparam int WEN_P_B    = 31;
   localparam int A_P_MSB    = 30;
   localparam int A_P_LSB    = 20;
   localparam int CEN_X_B    = 19;
   localparam int WEN_X_B    = 18;
   localparam int A_X_MSB    = 17;
   localparam int A_X_LSB    = 7;
   localparam int OFIFO_RD_B = 6;
   localparam int IFIFO_WR_B = 5;
   localparam int IFIFO_RD_B = 4;
   localparam int L0_RD_B    = 3;
   localparam int L0_WR_B    = 2;
   localparam int EXEC_B     = 1;
   localparam int LOAD_B     = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      EXEC  = 2'd2,
      DRAIN = 2'd3
   } phase_e;
endpackage

// File: rtl/inst_decoder_strobe_delay.sv
// N-stage strobe shift register; a kill bit drops that strobe as it enters the pipe.
module strobe_delay #(
   parameter int W = 2,
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   input  logic [W-1:0] kill_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] pipe_q [N];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= d_i & ~kill_i;
         for (int i = 1; i < N; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign q_o = pipe_q[N-1];
endmodule

// File: rtl/inst_decoder.sv
// Instruction decoder: registers inst fields, runs the IDLE/LOAD/EXEC/DRAIN phase FSM,
// keeps saturating activity counters. Define INST_DECODER_ERR_EN to build protocol-error logic.
module inst_decoder
   import core_pkg::*;
#(
   parameter int DRAIN_LEN = 10,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [INST_W-1:0]    inst,
   output logic                 mode_o,
   output logic                 acc_o,
   output logic                 cen_pmem_o,
   output logic                 wen_pmem_o,
   output logic [ADDR_W-1:0]    a_pmem_o,
   output logic                 cen_xmem_o,
   output logic                 wen_xmem_o,
   output logic [ADDR_W-1:0]    a_xmem_o,
   output logic                 ofifo_rd_o,
   output logic                 ififo_rd_o,
   output logic                 l0_rd_o,
   output logic                 ififo_wr_o,
   output logic                 l0_wr_o,
   output logic                 execute_o,
   output logic                 load_o,
   output logic [1:0]           phase_o,
   output logic [CNT_W-1:0]     load_cnt_o,
   output logic [CNT_W-1:0]     exec_cnt_o,
   output logic [CNT_W-1:0]     psum_wr_cnt_o,
   output logic [2:0]           err_o
);
   localparam int DW = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

   logic              mode_q, acc_q, cen_p_q, wen_p_q, cen_x_q, wen_x_q;
   logic [ADDR_W-1:0] a_p_q, a_x_q;
   logic              ofifo_rd_q, ififo_rd_q, l0_rd_q, exec_q, load_q;
   phase_e            phase_q, phase_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [CNT_W-1:0]  load_cnt_q, load_cnt_d, exec_cnt_q, exec_cnt_d, psum_cnt_q, psum_cnt_d;
   logic [2:0]        err_q, err_d;
   logic              l0_kill, force_off;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

`ifdef INST_DECODER_ERR_EN
   logic both_raw, mode_chg;
   assign both_raw  = inst[LOAD_B] & inst[EXEC_B];
   assign mode_chg  = (inst[MODE_B] != mode_q) && (phase_q != IDLE);
   assign l0_kill   = ~inst[CEN_X_B] & ~inst[WEN_X_B] & inst[L0_WR_B];
   assign err_d     = err_q | {l0_kill, mode_chg, both_raw};
   assign force_off = load_q & exec_q;
`else
   assign l0_kill   = 1'b0;
   assign err_d     = '0;
   assign force_off = 1'b0;
`endif

   // FIFO writes lag two cycles so they line up with the SRAM read data.
   strobe_delay #(.W(2), .N(2)) u_wr_dly (
      .clk    (clk),
      .reset  (reset),
      .d_i    ({inst[IFIFO_WR_B], inst[L0_WR_B]}),
      .kill_i ({1'b0, l0_kill}),
      .q_o    ({ififo_wr_o, l0_wr_o})
   );

   // Counters count on the cycle whose next phase is the counted phase, so the
   // entry cycle is included and the clear on entry happens before that count.
   always_comb begin
      phase_d    = phase_q;
      drain_d    = drain_q;
      load_cnt_d = load_cnt_q;
      exec_cnt_d = exec_cnt_q;
      psum_cnt_d = psum_cnt_q;
      unique case (phase_q)
         IDLE: begin
            if (load_q && !exec_q)      phase_d = LOAD;
            else if (exec_q && !load_q) phase_d = EXEC;
         end
         LOAD: if (!load_q) phase_d = IDLE;
         EXEC: begin
            if (!exec_q) begin
               phase_d = DRAIN;
               drain_d = '0;
            end
         end
         DRAIN: begin
            if (load_q && exec_q) begin
               phase_d = DRAIN;
            end else if (exec_q) begin
               phase_d = EXEC;
               drain_d = '0;
            end else if (drain_q == DW'(DRAIN_LEN - 1)) begin
               phase_d = IDLE;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         default: phase_d = IDLE;
      endcase
      if (phase_q == IDLE && phase_d == LOAD) load_cnt_d = '0;
      if (phase_d == LOAD && load_q)          load_cnt_d = sat_inc(load_cnt_d);
      if (phase_q == IDLE && phase_d == EXEC) exec_cnt_d = '0;
      if (phase_d == EXEC && l0_rd_q)         exec_cnt_d = sat_inc(exec_cnt_d);
      if (!cen_p_q && !wen_p_q && ofifo_rd_q) psum_cnt_d = sat_inc(psum_cnt_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q     <= 1'b0;
         acc_q      <= 1'b0;
         cen_p_q    <= 1'b1;
         wen_p_q    <= 1'b1;
         a_p_q      <= '0;
         cen_x_q    <= 1'b1;
         wen_x_q    <= 1'b1;
         a_x_q      <= '0;
         ofifo_rd_q <= 1'b0;
         ififo_rd_q <= 1'b0;
         l0_rd_q    <= 1'b0;
         exec_q     <= 1'b0;
         load_q     <= 1'b0;
         phase_q    <= IDLE;
         drain_q    <= '0;
         load_cnt_q <= '0;
         exec_cnt_q <= '0;
         psum_cnt_q <= '0;
         err_q      <= '0;
      end else begin
         mode_q     <= inst[MODE_B];
         acc_q      <= inst[ACC_B];
         cen_p_q    <= inst[CEN_P_B];
         wen_p_q    <= inst[WEN_P_B];
         a_p_q      <= inst[A_P_MSB:A_P_LSB];
         cen_x_q    <= inst[CEN_X_B];
         wen_x_q    <= inst[WEN_X_B];
         a_x_q      <= inst[A_X_MSB:A_X_LSB];
         ofifo_rd_q <= inst[OFIFO_RD_B];
         ififo_rd_q <= inst[IFIFO_RD_B];
         l0_rd_q    <= inst[L0_RD_B];
         exec_q     <= inst[EXEC_B];
         load_q     <= inst[LOAD_B];
         phase_q    <= phase_d;
         drain_q    <= drain_d;
         load_cnt_q <= load_cnt_d;
         exec_cnt_q <= exec_cnt_d;
         psum_cnt_q <= psum_cnt_d;
         err_q      <= err_d;
      end
   end

   assign mode_o        = mode_q;
   assign acc_o         = acc_q;
   assign cen_pmem_o    = cen_p_q;
   assign wen_pmem_o    = wen_p_q;
   assign a_pmem_o      = a_p_q;
   assign cen_xmem_o    = cen_x_q;
   assign wen_xmem_o    = wen_x_q;
   assign a_xmem_o      = a_x_q;
   assign ofifo_rd_o    = ofifo_rd_q;
   assign ififo_rd_o    = ififo_rd_q;
   assign l0_rd_o       = l0_rd_q;
   assign execute_o     = exec_q & ~force_off;
   assign load_o        = load_q & ~force_off;
   assign phase_o       = phase_q;
   assign load_cnt_o    = load_cnt_q;
   assign exec_cnt_o    = exec_cnt_q;
   assign psum_wr_cnt_o = psum_cnt_q;
   assign err_o         = err_q;
endmodule

// File: tb/tb_inst_decoder.sv
// Scoreboard bench for inst_decoder: drivers queue expected values per cycle, a negedge monitor checks them.
module tb_inst_decoder;
`ifdef INST_DECODER_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam logic [34:0] NOP    = 35'h1_800C_0000;
   localparam logic [34:0] B_LOAD = 35'h1;
   localparam logic [34:0] B_EXEC = 35'h2;
   localparam logic [34:0] B_L0WR = 35'h4;
   localparam logic [34:0] B_L0RD = 35'h8;
   localparam logic [34:0] B_IFRD = 35'h10;
   localparam logic [34:0] B_IFWR = 35'h20;
   localparam logic [34:0] B_OFRD = 35'h40;
   localparam logic [34:0] B_WENX = 35'h4_0000;
   localparam logic [34:0] B_CENX = 35'h8_0000;
   localparam logic [34:0] B_WENP = 35'h8000_0000;
   localparam logic [34:0] B_CENP = 35'h1_0000_0000;
   localparam logic [34:0] B_ACC  = 35'h2_0000_0000;
   localparam logic [34:0] B_MODE = 35'h4_0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [34:0] inst = '0;

   logic mode_o, acc_o, cen_pmem_o, wen_pmem_o, cen_xmem_o, wen_xmem_o;
   logic [10:0] a_pmem_o, a_xmem_o;
   logic ofifo_rd_o, ififo_rd_o, l0_rd_o, ififo_wr_o, l0_wr_o, execute_o, load_o;
   logic [1:0] phase_o;
   logic [7:0] load_cnt_o, exec_cnt_o, psum_wr_cnt_o;
   logic [2:0] err_o;

   logic mode4, acc4, cenp4, wenp4, cenx4, wenx4;
   logic [10:0] ap4, ax4;
   logic ofrd4, ifrd4, l0rd4, ifwr4, l0wr4, exe4, load4;
   logic [1:0] phase4;
   logic [3:0] lcnt4, ecnt4, pcnt4;
   logic [2:0] err4;

   inst_decoder #(.DRAIN_LEN(10), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .inst(inst),
      .mode_o(mode_o), .acc_o(acc_o), .cen_pmem_o(cen_pmem_o), .wen_pmem_o(wen_pmem_o),
      .a_pmem_o(a_pmem_o), .cen_xmem_o(cen_xmem_o), .wen_xmem_o(wen_xmem_o), .a_xmem_o(a_xmem_o),
      .ofifo_rd_o(ofifo_rd_o), .ififo_rd_o(ififo_rd_o), .l0_rd_o(l0_rd_o),
      .ififo_wr_o(ififo_wr_o), .l0_wr_o(l0_wr_o), .execute_o(execute_o), .load_o(load_o),
      .phase_o(phase_o), .load_cnt_o(load_cnt_o), .exec_cnt_o(exec_cnt_o),
      .psum_wr_cnt_o(psum_wr_cnt_o), .err_o(err_o)
   );

   inst_decoder #(.DRAIN_LEN(10), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .inst(inst),
      .mode_o(mode4), .acc_o(acc4), .cen_pmem_o(cenp4), .wen_pmem_o(wenp4),
      .a_pmem_o(ap4), .cen_xmem_o(cenx4), .wen_xmem_o(wenx4), .a_xmem_o(ax4),
      .ofifo_rd_o(ofrd4), .ififo_rd_o(ifrd4), .l0_rd_o(l0rd4),
      .ififo_wr_o(ifwr4), .l0_wr_o(l0wr4), .execute_o(exe4), .load_o(load4),
      .phase_o(phase4), .load_cnt_o(lcnt4), .exec_cnt_o(ecnt4),
      .psum_wr_cnt_o(pcnt4), .err_o(err4)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {
      S_PHASE, S_LCNT, S_ECNT, S_PCNT, S_PCNT4, S_CENP, S_WENP, S_AP, S_CENX, S_WENX,
      S_AX, S_L0WR, S_IFWR, S_OFRD, S_IFRD, S_EXE, S_LOAD, S_MODE, S_ACC, S_ERR
   } sig_e;

   typedef struct {
      int          at;
      sig_e        sig;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic expect_at(input int at, input sig_e s, input logic [31:0] v, input string nm);
      exp_t e;
      e.at = at; e.sig = s; e.val = v; e.name = nm;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] sample(input sig_e s);
      case (s)
         S_PHASE: return 32'(phase_o);
         S_LCNT:  return 32'(load_cnt_o);
         S_ECNT:  return 32'(exec_cnt_o);
         S_PCNT:  return 32'(psum_wr_cnt_o);
         S_PCNT4: return 32'(pcnt4);
         S_CENP:  return 32'(cen_pmem_o);
         S_WENP:  return 32'(wen_pmem_o);
         S_AP:    return 32'(a_pmem_o);
         S_CENX:  return 32'(cen_xmem_o);
         S_WENX:  return 32'(wen_xmem_o);
         S_AX:    return 32'(a_xmem_o);
         S_L0WR:  return 32'(l0_wr_o);
         S_IFWR:  return 32'(ififo_wr_o);
         S_OFRD:  return 32'(ofifo_rd_o);
         S_IFRD:  return 32'(ififo_rd_o);
         S_EXE:   return 32'(execute_o);
         S_LOAD:  return 32'(load_o);
         S_MODE:  return 32'(mode_o);
         S_ACC:   return 32'(acc_o);
         default: return 32'(err_o);
      endcase
   endfunction

   always @(negedge clk) begin
      logic [31:0] got;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc) begin
            got = sample(sb[i].sig);
            checks++;
            if (got !== sb[i].val) begin
               errors++;
               $display("FAIL %s @cyc %0d: got %0h, expected %0h", sb[i].name, cyc, got, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   task automatic drive(input logic rst, input logic [34:0] v);
      @(posedge clk);
      #1;
      reset = rst;
      inst  = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at cyc %0d", cyc);
      $fatal(1);
   end

   initial begin
      int T, L, E, F, P, X, Y, Z, R;
      logic [63:0] r;
      logic [34:0] v;

      // Reset held 10 cycles with random instructions.
      for (int i = 0; i < 10; i++) begin
         r = {$urandom(), $urandom()};
         drive(1'b1, r[34:0]);
         expect_at(cyc + 1, S_PHASE, 0, "rst_phase");
         expect_at(cyc + 1, S_L0WR, 0, "rst_l0wr");
         if (i == 9) begin
            expect_at(cyc + 1, S_LCNT, 0, "rst_lcnt");
            expect_at(cyc + 1, S_ECNT, 0, "rst_ecnt");
            expect_at(cyc + 1, S_PCNT, 0, "rst_pcnt");
            expect_at(cyc + 1, S_CENP, 1, "rst_cenp");
            expect_at(cyc + 1, S_WENP, 1, "rst_wenp");
            expect_at(cyc + 1, S_CENX, 1, "rst_cenx");
            expect_at(cyc + 1, S_WENX, 1, "rst_wenx");
            expect_at(cyc + 1, S_IFWR, 0, "rst_ifwr");
            expect_at(cyc + 1, S_LOAD, 0, "rst_load");
            expect_at(cyc + 1, S_EXE, 0, "rst_exe");
            expect_at(cyc + 1, S_ERR, 0, "rst_err");
         end
      end
      @(negedge clk);
      checks++;
      if (phase_o !== 2'd0) begin
         errors++;
         $display("FAIL rst_direct_phase: got %0h", phase_o);
      end
      checks++;
      if (load_cnt_o !== 8'd0 || exec_cnt_o !== 8'd0) begin
         errors++;
         $display("FAIL rst_direct_cnt: got %0h %0h", load_cnt_o, exec_cnt_o);
      end
      checks++;
      if (cen_pmem_o !== 1'b1 || wen_xmem_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_direct_cenwen: got %0b %0b", cen_pmem_o, wen_xmem_o);
      end
      checks++;
      if (l0_wr_o !== 1'b0 || ififo_wr_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_direct_strobe: got %0b %0b", l0_wr_o, ififo_wr_o);
      end
      checks++;
      if (psum_wr_cnt_o !== 8'd0) begin
         errors++;
         $display("FAIL rst_direct_pcnt: got %0h", psum_wr_cnt_o);
      end
      drive(1'b0, NOP);
      drive(1'b0, NOP);

      // Strobe alignment against the xmem read.
      drive(1'b0, (NOP & ~B_CENX) | (35'h400 << 7) | B_L0WR | B_IFWR | B_IFRD | B_ACC);
      T = cyc;
      expect_at(T + 1, S_CENX, 0, "aln_cenx");
      expect_at(T + 1, S_WENX, 1, "aln_wenx");
      expect_at(T + 1, S_AX, 32'h400, "aln_ax");
      expect_at(T + 1, S_L0WR, 0, "aln_l0wr_early");
      expect_at(T + 1, S_IFRD, 1, "aln_ifrd");
      expect_at(T + 1, S_ACC, 1, "aln_acc");
      expect_at(T + 2, S_L0WR, 1, "aln_l0wr");
      expect_at(T + 2, S_IFWR, 1, "aln_ifwr");
      expect_at(T + 2, S_CENX, 1, "aln_cenx_done");
      expect_at(T + 3, S_L0WR, 0, "aln_l0wr_late");
      for (int i = 0; i < 3; i++) drive(1'b0, NOP);

      // Load phase for 17 cycles.
      for (int i = 0; i < 17; i++) begin
         drive(1'b0, NOP | B_LOAD);
         if (i == 0) begin
            L = cyc;
            expect_at(L + 1, S_PHASE, 0, "ld_phase_pre");
            expect_at(L + 1, S_LOAD, 1, "ld_load_o");
            expect_at(L + 2, S_PHASE, 1, "ld_phase_enter");
            expect_at(L + 2, S_LCNT, 1, "ld_cnt_first");
            expect_at(L + 18, S_PHASE, 1, "ld_phase_last");
            expect_at(L + 18, S_LOAD, 0, "ld_load_o_off");
            expect_at(L + 19, S_PHASE, 0, "ld_phase_idle");
            expect_at(L + 19, S_LCNT, 17, "ld_cnt");
         end
      end
      for (int i = 0; i < 4; i++) drive(1'b0, NOP);

      // Execute for 36 cycles then full drain.
      for (int i = 0; i < 49; i++) begin
         drive(1'b0, (i < 36) ? (NOP | B_EXEC | B_L0RD) : NOP);
         if (i == 0) begin
            E = cyc;
            expect_at(E + 2, S_PHASE, 2, "ex_phase_enter");
            expect_at(E + 37, S_PHASE, 2, "ex_phase_last");
            expect_at(E + 37, S_ECNT, 36, "ex_cnt");
            expect_at(E + 38, S_PHASE, 3, "dr_first");
            expect_at(E + 47, S_PHASE, 3, "dr_tenth");
            expect_at(E + 48, S_PHASE, 0, "dr_idle");
            expect_at(E + 48, S_ECNT, 36, "ex_cnt_hold");
         end
      end

      // Short execute, re-enter EXEC in drain cycle 5.
      for (int i = 0; i < 25; i++) begin
         if (i < 4)       v = NOP | B_EXEC | B_L0RD;
         else if (i == 9) v = NOP | B_EXEC;
         else             v = NOP;
         drive(1'b0, v);
         if (i == 0) begin
            F = cyc;
            expect_at(F + 2, S_ECNT, 1, "ex2_cnt_clear");
            expect_at(F + 5, S_PHASE, 2, "ex2_phase");
            expect_at(F + 5, S_ECNT, 4, "ex2_cnt");
            expect_at(F + 6, S_PHASE, 3, "dr2_first");
            expect_at(F + 10, S_PHASE, 3, "dr2_fifth");
            expect_at(F + 11, S_PHASE, 2, "dr2_reexec");
            expect_at(F + 11, S_ECNT, 4, "dr2_cnt_keep");
            expect_at(F + 12, S_PHASE, 3, "dr3_first");
            expect_at(F + 21, S_PHASE, 3, "dr3_tenth");
            expect_at(F + 22, S_PHASE, 0, "dr3_idle");
         end
      end

      // 20 psum writes: CNT_W=8 counts to 20, CNT_W=4 saturates at 15.
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, (NOP & ~B_CENP & ~B_WENP) | B_OFRD | (35'(i) << 20));
         if (i == 0) begin
            P = cyc;
            expect_at(P + 1, S_CENP, 0, "ps_cenp");
            expect_at(P + 1, S_WENP, 0, "ps_wenp");
            expect_at(P + 1, S_OFRD, 1, "ps_ofrd");
            expect_at(P + 20, S_AP, 19, "ps_ap");
            expect_at(P + 15, S_PCNT4, 14, "ps4_14");
            expect_at(P + 16, S_PCNT4, 15, "ps4_15");
            expect_at(P + 21, S_PCNT4, 15, "ps4_sat");
            expect_at(P + 21, S_PCNT, 20, "ps8_20");
            expect_at(P + 22, S_PCNT, 20, "ps8_hold");
         end
      end
      for (int i = 0; i < 3; i++) drive(1'b0, NOP);

      // load and execute together in IDLE.
      drive(1'b0, NOP | B_LOAD | B_EXEC);
      X = cyc;
      expect_at(X + 1, S_LOAD, ERR_EN ? 0 : 1, "both_load_o");
      expect_at(X + 1, S_EXE, ERR_EN ? 0 : 1, "both_exe_o");
      expect_at(X + 1, S_ERR, ERR_EN ? 1 : 0, "both_err");
      expect_at(X + 2, S_PHASE, 0, "both_hold");
      expect_at(X + 3, S_PHASE, 0, "both_hold2");
      drive(1'b0, NOP);
      drive(1'b0, NOP);

      // Mode toggled during EXEC.
      for (int i = 0; i < 20; i++) begin
         if (i < 3)      v = NOP | B_EXEC;
         else if (i < 6) v = NOP | B_EXEC | B_MODE;
         else            v = NOP;
         drive(1'b0, v);
         if (i == 0) begin
            Y = cyc;
            expect_at(Y + 3, S_PHASE, 2, "md_phase");
            expect_at(Y + 3, S_MODE, 0, "md_mode_pre");
            expect_at(Y + 4, S_MODE, 1, "md_mode");
            expect_at(Y + 4, S_ERR, ERR_EN ? 3 : 0, "md_err");
            expect_at(Y + 19, S_PHASE, 0, "md_idle");
            expect_at(Y + 19, S_ERR, ERR_EN ? 3 : 0, "md_err_sticky");
         end
      end

      // xmem write with l0_wr in the same instruction.
      drive(1'b0, (NOP & ~B_CENX & ~B_WENX) | B_L0WR);
      Z = cyc;
      expect_at(Z + 1, S_WENX, 0, "xw_wenx");
      expect_at(Z + 1, S_ERR, ERR_EN ? 7 : 0, "xw_err");
      expect_at(Z + 2, S_L0WR, ERR_EN ? 0 : 1, "xw_l0wr");
      drive(1'b0, NOP);
      drive(1'b0, NOP);

      // Reset one cycle after an l0_wr instruction, mid-EXEC.
      for (int i = 0; i < 3; i++) drive(1'b0, NOP | B_EXEC);
      drive(1'b0, NOP | B_EXEC | B_L0WR | B_L0RD);
      R = cyc;
      expect_at(R + 1, S_PHASE, 2, "mr_phase_pre");
      expect_at(R + 1, S_L0WR, 0, "mr_l0wr_1");
      expect_at(R + 2, S_L0WR, 0, "mr_l0wr_2");
      expect_at(R + 3, S_L0WR, 0, "mr_l0wr_3");
      expect_at(R + 4, S_L0WR, 0, "mr_l0wr_4");
      expect_at(R + 2, S_PHASE, 0, "mr_phase");
      expect_at(R + 2, S_ERR, 0, "mr_err");
      expect_at(R + 2, S_PCNT, 0, "mr_pcnt");
      expect_at(R + 2, S_ECNT, 0, "mr_ecnt");
      expect_at(R + 2, S_EXE, 0, "mr_exe");
      expect_at(R + 2, S_CENX, 1, "mr_cenx");
      expect_at(R + 4, S_PHASE, 0, "mr_phase_after");
      drive(1'b1, NOP | B_EXEC);
      drive(1'b1, NOP);
      for (int i = 0; i < 4; i++) drive(1'b0, NOP);

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      foreach (sb[i]) begin
         checks++;
         errors++;
         $display("FAIL %s: expectation for cyc %0d never checked, expected %0h", sb[i].name, sb[i].at, sb[i].val);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
